// File: rtl/regfile_ctrl_pkg.sv
// Shared opcode/state types for the register-file command front-end.
package regfile_ctrl_pkg;

    typedef enum logic [1:0] {
        WRITE    = 2'd0,
        READ     = 2'd1,
        SET_BITS = 2'd2,
        CLR_BITS = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } state_e;

    localparam int MAX_RD_LATENCY = 3;

endpackage

// File: rtl/regfile_cmd_ctrl.sv
// Command front-end sequencing a register file: write, read and read-modify-write
// bit set/clear, one command in flight, one response per command.
module regfile_cmd_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int MEM_WIDTH    = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int MEM_DEPTH    = 16,
    parameter int RD_LATENCY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  op_e                     cmd_op,
    input  logic [ADDRESS_SIZE-1:0] cmd_addr,
    input  logic [MEM_WIDTH-1:0]    cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [MEM_WIDTH-1:0]    rsp_data,
    output logic                    rsp_err,
    output logic [MEM_WIDTH-1:0]    rf_data_in,
    output logic [ADDRESS_SIZE-1:0] rf_address_in,
    output logic                    rf_write_read_n,
    input  logic [MEM_WIDTH-1:0]    rf_data_out,
    output logic                    busy
);

    localparam int CNT_W = $clog2(MAX_RD_LATENCY);

    state_e                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    op_e                     op_q, op_n;
    logic [MEM_WIDTH-1:0]    data_q, data_n;
    logic [MEM_WIDTH-1:0]    rf_data_in_n;
    logic [ADDRESS_SIZE-1:0] rf_address_in_n;
    logic                    rf_wr_n;
    logic                    rsp_valid_n;
    logic [MEM_WIDTH-1:0]    rsp_data_n;
    logic                    rsp_err_n;
    logic                    rd_done;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_q            <= WRITE;
            data_q          <= '0;
            rf_data_in      <= '0;
            rf_address_in   <= '0;
            rf_write_read_n <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            op_q            <= op_n;
            data_q          <= data_n;
            rf_data_in      <= rf_data_in_n;
            rf_address_in   <= rf_address_in_n;
            rf_write_read_n <= rf_wr_n;
            rsp_valid       <= rsp_valid_n;
            rsp_data        <= rsp_data_n;
            rsp_err         <= rsp_err_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        op_n            = op_q;
        data_n          = data_q;
        rf_data_in_n    = rf_data_in;
        rf_address_in_n = rf_address_in;
        rf_wr_n         = 1'b0;
        rsp_valid_n     = rsp_valid;
        rsp_data_n      = rsp_data;
        rsp_err_n       = rsp_err;
        rd_done         = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n   = cmd_op;
                    data_n = cmd_data;
                    if (int'(cmd_addr) >= MEM_DEPTH) begin
                        // Out-of-range: answer immediately, never touch the register file.
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end else begin
                        rf_address_in_n = cmd_addr;
                        if (cmd_op == WRITE) begin
                            rf_data_in_n = cmd_data;
                            rf_wr_n      = 1'b1;
                            state_n      = WR_ISSUE;
                        end else begin
                            state_n = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: begin
                if (RD_LATENCY <= 1) begin
                    rd_done = 1'b1;
                end else begin
                    cnt_n   = CNT_W'(RD_LATENCY - 2);
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) rd_done = 1'b1;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            WR_ISSUE: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                if (op_q == WRITE) rsp_data_n = data_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Read data is valid now; bit ops report the pre-modification value.
        if (rd_done) begin
            rsp_data_n = rf_data_out;
            rsp_err_n  = 1'b0;
            if (op_q == READ) begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
            end else begin
                state_n      = WR_ISSUE;
                rf_wr_n      = 1'b1;
                rf_data_in_n = (op_q == SET_BITS) ? (rf_data_out | data_q)
                                                  : (rf_data_out & ~data_q);
            end
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: two instances (read latency 1 / depth 12 and
// read latency 3 / depth 16), each driving a behavioural register file.
module tb_regfile_cmd_ctrl;
    import regfile_ctrl_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       rst       [2];
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    op_e        cmd_op    [2];
    logic [3:0] cmd_addr  [2];
    logic [7:0] cmd_data  [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic [7:0] rf_din    [2];
    logic [3:0] rf_addr   [2];
    logic       rf_wr     [2];
    logic [7:0] rf_dout   [2];
    logic       busy      [2];

    logic [7:0] mem [2][16];
    logic       mem_clr;
    logic [3:0] a1_d1, a1_d2;

    exp_t       exp_q [2][$];
    logic       prev_valid [2] = '{1'b0, 1'b0};
    logic       prev_wr    [2] = '{1'b0, 1'b0};
    logic [7:0] hold_data  [2];
    logic       hold_err   [2];
    int         wr_cnt     [2] = '{0, 0};
    int         last_wa    [2] = '{0, 0};
    int         last_wd    [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_cmd_ctrl #(.MEM_WIDTH(8), .ADDRESS_SIZE(4), .MEM_DEPTH(12), .RD_LATENCY(1)) dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_err(rsp_err[0]), .rf_data_in(rf_din[0]), .rf_address_in(rf_addr[0]),
        .rf_write_read_n(rf_wr[0]), .rf_data_out(rf_dout[0]), .busy(busy[0])
    );

    regfile_cmd_ctrl #(.MEM_WIDTH(8), .ADDRESS_SIZE(4), .MEM_DEPTH(16), .RD_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_err(rsp_err[1]), .rf_data_in(rf_din[1]), .rf_address_in(rf_addr[1]),
        .rf_write_read_n(rf_wr[1]), .rf_data_out(rf_dout[1]), .busy(busy[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 12 : 16;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Register file models: instance 0 reads combinationally, instance 1 after a 2-stage address pipe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_clr) begin
                for (int i = 0; i < 16; i++) mem[d][i] <= 8'h00;
            end else if (rf_wr[d] && int'(rf_addr[d]) < depth_of(d)) begin
                mem[d][rf_addr[d]] <= rf_din[d];
            end
        end
        a1_d1 <= rf_addr[1];
        a1_d2 <= a1_d1;
    end
    assign rf_dout[0] = mem[0][rf_addr[0]];
    assign rf_dout[1] = mem[1][a1_d2];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each new response, checks hold stability and write pulses.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1 && prev_valid[d] !== 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("unexpected_rsp%0d", d), 1, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("rsp_data%0d", d), int'(rsp_data[d]), int'(e.data));
                    chk($sformatf("rsp_err%0d", d), int'(rsp_err[d]), int'(e.err));
                    chk($sformatf("rsp_cycle%0d", d), cyc, e.cyc);
                end
                hold_data[d] = rsp_data[d];
                hold_err[d]  = rsp_err[d];
            end else if (rsp_valid[d] === 1'b1) begin
                chk($sformatf("rsp_data_hold%0d", d), int'(rsp_data[d]), int'(hold_data[d]));
                chk($sformatf("rsp_err_hold%0d", d), int'(rsp_err[d]), int'(hold_err[d]));
            end
            prev_valid[d] = (rsp_valid[d] === 1'b1);

            if (rf_wr[d] === 1'b1) begin
                wr_cnt[d]++;
                last_wa[d] = int'(rf_addr[d]);
                last_wd[d] = int'(rf_din[d]);
                chk($sformatf("wr_pulse_single%0d", d), int'(prev_wr[d]), 0);
                chk($sformatf("wr_addr_in_range%0d", d), int'(int'(rf_addr[d]) < depth_of(d)), 1);
            end
            prev_wr[d] = (rf_wr[d] === 1'b1);
        end
    end

    task automatic send(input int d, input op_e op, input logic [3:0] addr, input logic [7:0] data,
                        input logic [7:0] exp_data, input logic exp_err, input bit push);
        int t;
        int lat;
        exp_t e;
        @(negedge clk);
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_addr[d]  = addr;
        cmd_data[d]  = data;
        t = 0;
        while (!cmd_ready[d] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk($sformatf("accept_timeout%0d", d), 0, 1);
            cmd_valid[d] = 1'b0;
            return;
        end
        if (exp_err)          lat = 1;
        else if (op == WRITE) lat = 2;
        else if (op == READ)  lat = 1 + lat_of(d);
        else                  lat = 2 + lat_of(d);
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc + lat;
        if (push) exp_q[d].push_back(e);
        @(posedge clk);
        #1;
        // Scramble the inputs: the command must already be latched.
        cmd_valid[d] = 1'b0;
        cmd_op[d]    = WRITE;
        cmd_addr[d]  = ~addr;
        cmd_data[d]  = ~data;
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        while ((exp_q[d].size() != 0 || !cmd_ready[d]) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk($sformatf("idle_timeout%0d", d), 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int t;
        rst       = '{1'b1, 1'b1};
        mem_clr   = 1'b1;
        cmd_valid = '{1'b0, 1'b0};
        cmd_op    = '{WRITE, WRITE};
        cmd_addr  = '{4'h0, 4'h0};
        cmd_data  = '{8'h00, 8'h00};
        rsp_ready = '{1'b1, 1'b1};
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", int'(rsp_valid[d]), 0);
            chk("rst_rsp_data",  int'(rsp_data[d]), 0);
            chk("rst_rsp_err",   int'(rsp_err[d]), 0);
            chk("rst_rf_wr",     int'(rf_wr[d]), 0);
            chk("rst_rf_addr",   int'(rf_addr[d]), 0);
            chk("rst_rf_din",    int'(rf_din[d]), 0);
            chk("rst_busy",      int'(busy[d]), 0);
            chk("rst_cmd_ready", int'(cmd_ready[d]), 0);
        end
        rst     = '{1'b0, 1'b0};
        mem_clr = 1'b0;

        // Instance 0: RD_LATENCY=1, MEM_DEPTH=12
        w0 = wr_cnt[0];
        send(0, WRITE, 4'd3, 8'h06, 8'h06, 1'b0, 1'b1);
        wait_idle(0);
        chk("wr_count_write", wr_cnt[0] - w0, 1);
        chk("wr_addr_write", last_wa[0], 3);
        chk("wr_data_write", last_wd[0], 'h06);
        send(0, READ,     4'd3, 8'h00, 8'h06, 1'b0, 1'b1);
        send(0, SET_BITS, 4'd3, 8'hF0, 8'h06, 1'b0, 1'b1);
        send(0, READ,     4'd3, 8'h00, 8'hF6, 1'b0, 1'b1);
        send(0, CLR_BITS, 4'd3, 8'h02, 8'hF6, 1'b0, 1'b1);
        send(0, READ,     4'd3, 8'h00, 8'hF4, 1'b0, 1'b1);
        wait_idle(0);
        chk("wr_data_clr", last_wd[0], 'hF4);

        w0 = wr_cnt[0];
        send(0, WRITE, 4'd13, 8'hAA, 8'h00, 1'b1, 1'b1);
        send(0, READ,  4'd13, 8'h00, 8'h00, 1'b1, 1'b1);
        send(0, WRITE, 4'd12, 8'h55, 8'h00, 1'b1, 1'b1);
        wait_idle(0);
        chk("wr_count_oor", wr_cnt[0] - w0, 0);
        send(0, READ,  4'd3,  8'h00, 8'hF4, 1'b0, 1'b1);
        send(0, WRITE, 4'd11, 8'h3C, 8'h3C, 1'b0, 1'b1);
        send(0, READ,  4'd11, 8'h00, 8'h3C, 1'b0, 1'b1);
        wait_idle(0);

        // Back-pressure on the response channel
        rsp_ready[0] = 1'b0;
        send(0, READ, 4'd3, 8'h00, 8'hF4, 1'b0, 1'b1);
        t = 0;
        while (!rsp_valid[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_seen", int'(rsp_valid[0]), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", int'(cmd_ready[0]), 0);
            chk("bp_busy", int'(busy[0]), 1);
            chk("bp_rsp_valid", int'(rsp_valid[0]), 1);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_cmd_ready_after", int'(cmd_ready[0]), 1);
        chk("bp_rsp_valid_after", int'(rsp_valid[0]), 0);

        // Reset in the cycle after a SET_BITS is accepted
        send(0, WRITE, 4'd5, 8'h11, 8'h11, 1'b0, 1'b1);
        wait_idle(0);
        w0 = wr_cnt[0];
        send(0, SET_BITS, 4'd5, 8'hFF, 8'h00, 1'b0, 1'b0);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("rst_abort_cmd_ready", int'(cmd_ready[0]), 1);
        chk("rst_abort_busy", int'(busy[0]), 0);
        repeat (4) @(negedge clk);
        chk("rst_abort_no_write", wr_cnt[0] - w0, 0);
        chk("rst_abort_no_rsp", int'(rsp_valid[0]), 0);
        send(0, READ, 4'd5, 8'h00, 8'h11, 1'b0, 1'b1);
        wait_idle(0);

        // Instance 1: RD_LATENCY=3, MEM_DEPTH=16
        send(1, WRITE,    4'd3,  8'h06, 8'h06, 1'b0, 1'b1);
        send(1, READ,     4'd3,  8'h00, 8'h06, 1'b0, 1'b1);
        send(1, SET_BITS, 4'd3,  8'hF0, 8'h06, 1'b0, 1'b1);
        send(1, READ,     4'd3,  8'h00, 8'hF6, 1'b0, 1'b1);
        send(1, CLR_BITS, 4'd3,  8'h02, 8'hF6, 1'b0, 1'b1);
        send(1, READ,     4'd3,  8'h00, 8'hF4, 1'b0, 1'b1);
        send(1, READ,     4'd15, 8'h00, 8'h00, 1'b0, 1'b1);
        send(1, WRITE,    4'd15, 8'h5A, 8'h5A, 1'b0, 1'b1);
        send(1, SET_BITS, 4'd15, 8'h81, 8'h5A, 1'b0, 1'b1);
        send(1, READ,     4'd15, 8'h00, 8'hDB, 1'b0, 1'b1);
        wait_idle(1);

        repeat (3) @(negedge clk);
        chk("sb_empty0", exp_q[0].size(), 0);
        chk("sb_empty1", exp_q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_cmd_ctrl.md
Name: regfile_cmd_ctrl

Overview:
- Command front-end that sits directly upstream of the parameterized register file.
- Accepts one command at a time over a valid/ready stream: WRITE, READ, SET_BITS or CLR_BITS.
- Sequences the register file's data/address/write_read_n pins, including read-modify-write for the bit ops.
- Returns exactly one response per command over a valid/ready stream.

Parameters:
- MEM_WIDTH, 8, data width; matches the register file.
- ADDRESS_SIZE, 4, address width; matches the register file.
- MEM_DEPTH, 16, number of implemented registers. Addresses >= MEM_DEPTH are errors.
- RD_LATENCY, 1, cycles from read address presented to rf_data_out valid. Legal range 1..3.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  operation code (regfile_ctrl_pkg::op_e).
- cmd_addr  in  ADDRESS_SIZE  target register.
- cmd_data  in  MEM_WIDTH  write data, or bit mask for SET_BITS/CLR_BITS.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  MEM_WIDTH  response data.
- rsp_err  out  1  address out of range.
- rf_data_in  out  MEM_WIDTH  to register file data_in.
- rf_address_in  out  ADDRESS_SIZE  to register file address_in.
- rf_write_read_n  out  1  to register file write_read_n; 1 means write.
- rf_data_out  in  MEM_WIDTH  from register file data_out.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, applied on any posedge with rst=1:
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_err=0.
  - rf_write_read_n=0, rf_address_in=0, rf_data_in=0, busy=0.
  - cmd_ready=0 while rst=1.
- Reset mid-operation aborts the command: no response, no further rf write, and the latched command is discarded.
- cmd_ready = (state==IDLE) && !rst. A command is accepted on a posedge with cmd_valid && cmd_ready.
- All rf_* outputs and rsp_* outputs are registered. rf_write_read_n is 1 for exactly one cycle per write; otherwise it is 0.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- Op codes: 0=WRITE, 1=READ, 2=SET_BITS, 3=CLR_BITS. Timing below takes the accept edge as the end of cycle N.
- WRITE:
  - N+1: WR_ISSUE with rf_address_in=addr, rf_data_in=cmd_data, rf_write_read_n=1.
  - N+2: RESP with rsp_data=cmd_data.
- READ:
  - N+1: RD_ISSUE with rf_address_in=addr, rf_write_read_n=0.
  - RD_WAIT lasts RD_LATENCY-1 cycles, counted by a 2-bit down-counter.
  - rf_data_out is sampled at the end of cycle N+RD_LATENCY.
  - rsp_valid=1 from N+1+RD_LATENCY, with rsp_data = sampled value.
- SET_BITS / CLR_BITS:
  - Read as for READ, then WR_ISSUE in cycle N+1+RD_LATENCY.
  - Written value is old|mask for SET_BITS, old&~mask for CLR_BITS.
  - RESP at N+2+RD_LATENCY; rsp_data = old value before modification.
- Out-of-range address (addr >= MEM_DEPTH):
  - No rf access; rf_write_read_n stays 0.
  - N+1: RESP with rsp_err=1, rsp_data=0.
- rsp_err=0 for all in-range responses.
- RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready=1. Then it returns to IDLE, and cmd_ready=1 in the next cycle. There is no cmd/rsp overlap.
- rsp_ready asserted before rsp_valid has no effect.
- cmd_valid changing while cmd_ready=0 is ignored. The command is latched at accept, so inputs may change afterwards.
- rf_address_in and rf_data_in hold their last values when idle.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - op_e (2-bit enum WRITE/READ/SET_BITS/CLR_BITS).
  - state_e (3-bit enum).
  - localparam MAX_RD_LATENCY=3.
- Single module; no sub-module is warranted. The bench instantiates the existing register file as the downstream model.

Test Plan:
1. Reset held 10 cycles, then WRITE addr=3 data=0x06 -> rf_write_read_n=1 in exactly one cycle with rf_address_in=3, rf_data_in=0x06; rsp_valid at accept+2 with rsp_data=0x06, rsp_err=0.
2. READ addr=3 with RD_LATENCY=1 -> rsp_valid at accept+2 with rsp_data=0x06. Repeat with RD_LATENCY=3 -> rsp_valid at accept+4.
3. SET_BITS addr=3 mask=0xF0, then READ addr=3 -> first rsp_data=0x06, second rsp_data=0xF6. Then CLR_BITS mask=0x02 -> rsp_data=0xF6, and a following READ returns 0xF4.
4. MEM_DEPTH=12, WRITE addr=13 data=0xAA -> rsp_err=1, rsp_data=0 at accept+1; no rf write pulse; READ addr=13 also errors and does not disturb register contents.
5. Back-pressure: rsp_ready=0 for 5 cycles after READ -> rsp_valid, rsp_data, rsp_err stable; cmd_ready=0 and busy=1 throughout; cmd_ready=1 the cycle after the rsp handshake.
6. rst pulsed in the cycle after SET_BITS addr=5 mask=0xFF is accepted (reg5=0x11) -> no write pulse, no response, reg5 still 0x11 on a subsequent READ, cmd_ready=1 the cycle after rst drops.
